// File: rtl/control_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_unit_pkg                                                           |
// | Opcode/funct constants, ALU op enum and pipeline control-word types.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package control_unit_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_VRTYPE  = 6'b010000;
  localparam logic [5:0] OP_VSCALAR = 6'b010001;
  localparam logic [5:0] OP_VLW     = 6'b010010;
  localparam logic [5:0] OP_VSW     = 6'b010101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } aluOp_t;

  // Full word latched into D->E; later stages keep only the fields they still need.
  typedef struct packed {
    logic   regwrite;
    logic   vregwrite;
    logic   memtoreg;
    logic   memwrite;
    logic   memdata;
    logic   memsrc;
    logic   alusrc;
    logic   scalar;
    logic   regdst;
    aluOp_t alucontrol;
  } ctrlWord_t;

  typedef struct packed {
    logic regwrite;
    logic vregwrite;
    logic memtoreg;
    logic memwrite;
    logic memdata;
    logic memsrc;
  } ctrlMem_t;

  typedef struct packed {
    logic regwrite;
    logic vregwrite;
    logic memtoreg;
  } ctrlWb_t;

  function automatic aluOp_t functToAluOp(input logic [5:0] funct);
    aluOp_t op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      FN_SLL:  op = ALU_SLL;
      FN_SRL:  op = ALU_SRL;
      FN_MUL:  op = ALU_MUL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_unit_if                                                            |
// | Decode-stage inputs and per-stage control outputs between datapath and CU. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface control_unit_if;
  logic [5:0]  opD;
  logic [5:0]  functD;
  logic [31:0] srca2D;
  logic [31:0] srcb2D;
  logic        flushE;

  logic        jumpD;
  logic [1:0]  branchD;
  logic        pcsrcD;

  logic        alusrcE;
  logic        scalarE;
  logic [2:0]  alucontrolE;
  logic        regdstE;
  logic        regwriteE;
  logic        memtoregE;

  logic        memwriteM;
  logic        memdataM;
  logic        memsrcM;
  logic        regwriteM;
  logic        memtoregM;

  logic        regwriteW;
  logic        VregwriteW;
  logic        memtoregW;

  // Datapath side
  modport master (
    output opD, functD, srca2D, srcb2D, flushE,
    input  jumpD, branchD, pcsrcD,
    input  alusrcE, scalarE, alucontrolE, regdstE, regwriteE, memtoregE,
    input  memwriteM, memdataM, memsrcM, regwriteM, memtoregM,
    input  regwriteW, VregwriteW, memtoregW
  );

  // Control unit side
  modport slave (
    input  opD, functD, srca2D, srcb2D, flushE,
    output jumpD, branchD, pcsrcD,
    output alusrcE, scalarE, alucontrolE, regdstE, regwriteE, memtoregE,
    output memwriteM, memdataM, memsrcM, regwriteM, memtoregM,
    output regwriteW, VregwriteW, memtoregW
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_decoder                                                            |
// | Combinational main decode and ALU decode from opD/functD.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] opD,
  input  logic [5:0] functD,
  output ctrlWord_t  ctrlD,
  output logic       jumpD,
  output logic [1:0] branchD
);

  // Unlisted opcodes fall through with the all-zero NOP word.
  always_comb begin
    ctrlD   = '0;
    jumpD   = 1'b0;
    branchD = BR_NONE;
    case (opD)
      OP_RTYPE: begin
        ctrlD.regwrite   = 1'b1;
        ctrlD.regdst     = 1'b1;
        ctrlD.alucontrol = functToAluOp(functD);
      end
      OP_ADDI: begin
        ctrlD.regwrite   = 1'b1;
        ctrlD.alusrc     = 1'b1;
        ctrlD.alucontrol = ALU_ADD;
      end
      OP_ANDI: begin
        ctrlD.regwrite   = 1'b1;
        ctrlD.alusrc     = 1'b1;
        ctrlD.alucontrol = ALU_AND;
      end
      OP_LW: begin
        ctrlD.regwrite   = 1'b1;
        ctrlD.alusrc     = 1'b1;
        ctrlD.memtoreg   = 1'b1;
        ctrlD.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrlD.memwrite   = 1'b1;
        ctrlD.alusrc     = 1'b1;
        ctrlD.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        branchD          = BR_EQ;
        ctrlD.alucontrol = ALU_SUB;
      end
      OP_BNE: begin
        branchD          = BR_NE;
        ctrlD.alucontrol = ALU_SUB;
      end
      OP_J: begin
        jumpD = 1'b1;
      end
      OP_VRTYPE: begin
        ctrlD.vregwrite  = 1'b1;
        ctrlD.regdst     = 1'b1;
        ctrlD.alucontrol = functToAluOp(functD);
      end
      OP_VSCALAR: begin
        ctrlD.vregwrite  = 1'b1;
        ctrlD.regdst     = 1'b1;
        ctrlD.scalar     = 1'b1;
        ctrlD.alucontrol = functToAluOp(functD);
      end
      OP_VLW: begin
        ctrlD.vregwrite  = 1'b1;
        ctrlD.alusrc     = 1'b1;
        ctrlD.memtoreg   = 1'b1;
        ctrlD.memdata    = 1'b1;
        ctrlD.alucontrol = ALU_ADD;
      end
      OP_VSW: begin
        ctrlD.memwrite   = 1'b1;
        ctrlD.alusrc     = 1'b1;
        ctrlD.memdata    = 1'b1;
        ctrlD.memsrc     = 1'b1;
        ctrlD.alucontrol = ALU_ADD;
      end
      default: begin
        ctrlD = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_unit                                                               |
// | Decode, branch resolution and D->E->M->W control pipeline.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_unit
  import control_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  control_unit_if.slave bus
);

  ctrlWord_t  ctrlD;
  ctrlWord_t  ctrlE;
  ctrlMem_t   ctrlM;
  ctrlWb_t    ctrlW;
  logic       jumpD;
  logic [1:0] branchD;
  logic       operandsEqual;

  control_decoder uDecoder (
    .opD     (bus.opD),
    .functD  (bus.functD),
    .ctrlD   (ctrlD),
    .jumpD   (jumpD),
    .branchD (branchD)
  );

  assign operandsEqual = (bus.srca2D == bus.srcb2D);

  assign bus.jumpD   = jumpD;
  assign bus.branchD = branchD;
  assign bus.pcsrcD  = ((branchD == BR_EQ) &&  operandsEqual) ||
                       ((branchD == BR_NE) && !operandsEqual);

  // flushE turns the D->E load into a bubble; reset dominates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlE <= '0;
    end else if (bus.flushE) begin
      ctrlE <= '0;
    end else begin
      ctrlE <= ctrlD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlM <= '0;
    end else begin
      ctrlM.regwrite  <= ctrlE.regwrite;
      ctrlM.vregwrite <= ctrlE.vregwrite;
      ctrlM.memtoreg  <= ctrlE.memtoreg;
      ctrlM.memwrite  <= ctrlE.memwrite;
      ctrlM.memdata   <= ctrlE.memdata;
      ctrlM.memsrc    <= ctrlE.memsrc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlW <= '0;
    end else begin
      ctrlW.regwrite  <= ctrlM.regwrite;
      ctrlW.vregwrite <= ctrlM.vregwrite;
      ctrlW.memtoreg  <= ctrlM.memtoreg;
    end
  end

  assign bus.alusrcE     = ctrlE.alusrc;
  assign bus.scalarE     = ctrlE.scalar;
  assign bus.alucontrolE = ctrlE.alucontrol;
  assign bus.regdstE     = ctrlE.regdst;
  assign bus.regwriteE   = ctrlE.regwrite;
  assign bus.memtoregE   = ctrlE.memtoreg;

  assign bus.memwriteM   = ctrlM.memwrite;
  assign bus.memdataM    = ctrlM.memdata;
  assign bus.memsrcM     = ctrlM.memsrc;
  assign bus.regwriteM   = ctrlM.regwrite;
  assign bus.memtoregM   = ctrlM.memtoreg;

  assign bus.regwriteW   = ctrlW.regwrite;
  assign bus.VregwriteW  = ctrlW.vregwrite;
  assign bus.memtoregW   = ctrlW.memtoreg;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_unit                                                            |
// | Directed + random stimulus against a table-driven pipeline reference.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_control_unit;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  control_unit_if cuIf ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cuIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       jump;
    logic [1:0] br;
    logic       rw;
    logic       vrw;
    logic       rd;
    logic       as;
    logic       sc;
    logic       m2r;
    logic       mw;
    logic       md;
    logic       ms;
    logic [2:0] alu;
  } refT;

  refT stE, stM, stW;

  function automatic logic [2:0] refAlu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'd0;
      6'b100010: return 3'd1;
      6'b100100: return 3'd2;
      6'b100101: return 3'd3;
      6'b101010: return 3'd4;
      6'b000000: return 3'd5;
      6'b000010: return 3'd6;
      6'b011000: return 3'd7;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic refT refDecode(input logic [5:0] op, input logic [5:0] fn);
    refT r;
    r = '0;
    case (op)
      6'b000000: begin r.rw = 1; r.rd = 1; r.alu = refAlu(fn); end
      6'b001000: begin r.rw = 1; r.as = 1; r.alu = 3'd0; end
      6'b001100: begin r.rw = 1; r.as = 1; r.alu = 3'd2; end
      6'b100011: begin r.rw = 1; r.as = 1; r.m2r = 1; end
      6'b101011: begin r.mw = 1; r.as = 1; end
      6'b000100: begin r.br = 2'b01; r.alu = 3'd1; end
      6'b000101: begin r.br = 2'b10; r.alu = 3'd1; end
      6'b000010: begin r.jump = 1; end
      6'b010000: begin r.vrw = 1; r.rd = 1; r.alu = refAlu(fn); end
      6'b010001: begin r.vrw = 1; r.rd = 1; r.sc = 1; r.alu = refAlu(fn); end
      6'b010010: begin r.vrw = 1; r.as = 1; r.m2r = 1; r.md = 1; end
      6'b010101: begin r.mw = 1; r.as = 1; r.md = 1; r.ms = 1; end
      default:   r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one Decode cycle, check mid-cycle, then advance the model on the edge.
  task automatic cycle(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic rs);
    refT d;
    logic expPc;
    cuIf.opD    = op;
    cuIf.functD = fn;
    cuIf.srca2D = a;
    cuIf.srcb2D = b;
    cuIf.flushE = fl;
    reset       = rs;
    d     = refDecode(op, fn);
    expPc = ((d.br == 2'b01) && (a == b)) || ((d.br == 2'b10) && (a != b));
    #3;
    chk("jumpD",       {31'd0, cuIf.jumpD},       {31'd0, d.jump});
    chk("branchD",     {30'd0, cuIf.branchD},     {30'd0, d.br});
    chk("pcsrcD",      {31'd0, cuIf.pcsrcD},      {31'd0, expPc});
    chk("alusrcE",     {31'd0, cuIf.alusrcE},     {31'd0, stE.as});
    chk("scalarE",     {31'd0, cuIf.scalarE},     {31'd0, stE.sc});
    chk("alucontrolE", {29'd0, cuIf.alucontrolE}, {29'd0, stE.alu});
    chk("regdstE",     {31'd0, cuIf.regdstE},     {31'd0, stE.rd});
    chk("regwriteE",   {31'd0, cuIf.regwriteE},   {31'd0, stE.rw});
    chk("memtoregE",   {31'd0, cuIf.memtoregE},   {31'd0, stE.m2r});
    chk("memwriteM",   {31'd0, cuIf.memwriteM},   {31'd0, stM.mw});
    chk("memdataM",    {31'd0, cuIf.memdataM},    {31'd0, stM.md});
    chk("memsrcM",     {31'd0, cuIf.memsrcM},     {31'd0, stM.ms});
    chk("regwriteM",   {31'd0, cuIf.regwriteM},   {31'd0, stM.rw});
    chk("memtoregM",   {31'd0, cuIf.memtoregM},   {31'd0, stM.m2r});
    chk("regwriteW",   {31'd0, cuIf.regwriteW},   {31'd0, stW.rw});
    chk("VregwriteW",  {31'd0, cuIf.VregwriteW},  {31'd0, stW.vrw});
    chk("memtoregW",   {31'd0, cuIf.memtoregW},   {31'd0, stW.m2r});
    @(posedge clk);
    if (rs) begin
      stE = '0; stM = '0; stW = '0;
    end else begin
      stW = stM;
      stM = stE;
      stE = fl ? refT'(0) : d;
    end
    #1;
  endtask

  logic [5:0] opList [12] = '{6'b000000, 6'b001000, 6'b001100, 6'b100011,
                              6'b101011, 6'b000100, 6'b000101, 6'b000010,
                              6'b010000, 6'b010001, 6'b010010, 6'b010101};
  logic [5:0] fnList [8]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b000000, 6'b000010, 6'b011000};

  initial begin
    logic [5:0]  op, fn;
    logic [31:0] a, b;
    tests = 0;
    fails = 0;
    stE = '0; stM = '0; stW = '0;
    reset       = 1'b1;
    cuIf.opD    = '0;
    cuIf.functD = '0;
    cuIf.srca2D = '0;
    cuIf.srcb2D = '0;
    cuIf.flushE = 1'b0;
    @(posedge clk);
    #1;

    // SLL R-type, then let it reach W
    cycle(6'b000000, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    // vector R-type ADD
    cycle(6'b010000, 6'b100000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    // BEQ equal / not equal, BNE both ways
    cycle(6'b000100, 6'b000000, 32'h5, 32'h5, 0, 0);
    cycle(6'b000100, 6'b000000, 32'h5, 32'h6, 0, 0);
    cycle(6'b000101, 6'b000000, 32'h5, 32'h6, 0, 0);
    cycle(6'b000101, 6'b000000, 32'h80000005, 32'h80000005, 0, 0);
    cycle(6'b000100, 6'b000000, 32'h80000005, 32'h00000005, 0, 0);
    // ANDI, vector-scalar, VLW, VSW, J
    cycle(6'b001100, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b010001, 6'b011000, 32'h0, 32'h0, 0, 0);
    cycle(6'b010010, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b010101, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b000010, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    // flushed LW propagates as a bubble
    cycle(6'b100011, 6'b000000, 32'h0, 32'h0, 1, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);
    // mid-stream reset, including reset together with flush
    cycle(6'b100011, 6'b000000, 32'h0, 32'h0, 0, 0);
    cycle(6'b000000, 6'b100010, 32'h0, 32'h0, 0, 0);
    cycle(6'b010010, 6'b000000, 32'h0, 32'h0, 0, 1);
    cycle(6'b101011, 6'b000000, 32'h0, 32'h0, 1, 1);
    cycle(6'b111111, 6'b000000, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opList[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 7)];
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? a : (($urandom_range(0, 1) == 0) ? a ^ (32'h1 << $urandom_range(0, 31)) : $urandom);
      cycle(op, fn, a, b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
